// File: rtl/symbol_stream_arbiter_pkg.sv
// Shared definitions for the symbol stream arbiter and the 1-2-3 sequence detector:
// detector state encoding, default sizes and the detector next-state function.
package symbol_stream_arbiter_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        S0 = 2'd0,  // idle
        S1 = 2'd1,  // "1" seen
        S2 = 2'd2,  // "1..2" seen
        S3 = 2'd3   // matched
    } det_state_t;

    typedef struct packed {
        det_state_t next;
        logic       match;
    } det_step_t;

    // One detector step on an accepted symbol; the match flag is set on entry to S3.
    function automatic det_step_t det_next(input det_state_t cur, input logic [1:0] sym);
        det_step_t r;
        r.next  = S0;
        r.match = 1'b0;
        case (cur)
            S0: if (sym == 2'd1) r.next = S1;
            S1: begin
                if (sym == 2'd1)      r.next = S1;
                else if (sym == 2'd2) r.next = S2;
            end
            S2: begin
                if (sym == 2'd1)      r.next = S1;
                else if (sym == 2'd2) r.next = S2;
                else if (sym == 2'd3) begin
                    r.next  = S3;
                    r.match = 1'b1;
                end
            end
            S3: begin
                if (sym == 2'd1)      r.next = S1;
                else if (sym == 2'd3) begin
                    r.next  = S3;
                    r.match = 1'b1;
                end
            end
            default: r.next = S0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/symbol_stream_arbiter_rr_arbiter4.sv
// Four-way round-robin grant: the first requester at or above ptr (wrapping 3->0)
// receives a one-hot grant; no request gives an all-zero grant.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt
);

    logic [1:0] w_idx;

    // NOTE: combinational logic uses blocking assignments with every output defaulted
    // first, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        gnt   = '0;
        w_idx = '0;
        // Walk the priority order backwards so the highest-priority requester lands last.
        for (int k = 3; k >= 0; k--) begin
            w_idx = ptr + 2'(k);
            if (req[w_idx]) begin
                gnt        = '0;
                gnt[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/symbol_stream_arbiter.sv
// Round-robin arbiter over four symbol streams feeding a shared 1-2-3 sequence detector
// with per-channel state, saturating per-channel match counters and a registered match report.
module symbol_stream_arbiter
    import symbol_stream_arbiter_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   req_valid,
    input  logic [2*NUM_CH-1:0] req_sym,
    output logic [NUM_CH-1:0]   req_ready,
    input  logic [NUM_CH-1:0]   clr,
    output logic                match_valid,
    output logic [1:0]          match_ch,
    output logic [CNT_W-1:0]    match_cnt
);

    det_state_t       r_state [4];
    logic [CNT_W-1:0] r_cnt   [4];
    logic [1:0]       r_ptr;
    logic             r_match_valid;
    logic [1:0]       r_match_ch;
    logic [CNT_W-1:0] r_match_cnt;

    logic [3:0]       w_eligible;
    logic [3:0]       w_gnt;
    logic [1:0]       w_gnt_id;
    logic             w_any;
    logic [1:0]       w_sym_sel;
    det_step_t        w_step;
    logic [CNT_W-1:0] w_cnt_next;

    // A channel being cleared sits out arbitration; nothing is granted during reset.
    assign w_eligible = req_valid & ~clr & {4{rst_n}};

    rr_arbiter4 u_rr_arbiter4 (
        .req (w_eligible),
        .ptr (r_ptr),
        .gnt (w_gnt)
    );

    assign req_ready = w_gnt;
    assign w_any     = |w_gnt;

    always_comb begin
        w_gnt_id = '0;
        for (int k = 0; k < 4; k++) begin
            if (w_gnt[k]) w_gnt_id = 2'(k);
        end
    end

    assign w_sym_sel  = req_sym[{w_gnt_id, 1'b0} +: 2];
    assign w_step     = det_next(r_state[w_gnt_id], w_sym_sel);
    assign w_cnt_next = (r_cnt[w_gnt_id] == {CNT_W{1'b1}}) ? r_cnt[w_gnt_id]
                                                           : r_cnt[w_gnt_id] + 1'b1;

    // NOTE: the per-channel state table and counters are a tiny register array, not a RAM,
    // so every entry is reset explicitly; the detector relies on starting from S0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                r_state[k] <= S0;
                r_cnt[k]   <= '0;
            end
            r_ptr         <= '0;
            r_match_valid <= 1'b0;
            r_match_ch    <= '0;
            r_match_cnt   <= '0;
        end else begin
            r_match_valid <= 1'b0;
            if (w_any) begin
                r_ptr            <= w_gnt_id + 2'd1;
                r_state[w_gnt_id] <= w_step.next;
                if (w_step.match) begin
                    r_cnt[w_gnt_id] <= w_cnt_next;
                    r_match_valid   <= 1'b1;
                    r_match_ch      <= w_gnt_id;
                    r_match_cnt     <= w_cnt_next;
                end
            end
            // A cleared channel is never the granted one, so these never collide.
            for (int k = 0; k < 4; k++) begin
                if (clr[k]) begin
                    r_state[k] <= S0;
                    r_cnt[k]   <= '0;
                end
            end
        end
    end

    assign match_valid = r_match_valid;
    assign match_ch    = r_match_ch;
    assign match_cnt   = r_match_cnt;

endmodule
